// File: rtl/score_pkg.sv
// Shared constants for the score keeper: BCD digit geometry and FSM state codes.
package score_pkg;
  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_NINE = 4'd9;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t RUN    = 2'd1;
  localparam state_t COMMIT = 2'd2;
  localparam state_t OVER   = 2'd3;
endpackage

// File: rtl/score_bcd_digit.sv
// One registered BCD digit; increments when enabled and a carry arrives from below.
module score_bcd_digit
  import score_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc_en,
  input  logic               carry_in,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry_out
);
  logic [DIGIT_W-1:0] digit_reg;

  assign digit     = digit_reg;
  assign carry_out = carry_in & (digit_reg == BCD_NINE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_reg <= '0;
    end else if (clr) begin
      digit_reg <= '0;
    end else if (inc_en && carry_in) begin
      digit_reg <= (digit_reg == BCD_NINE) ? '0 : digit_reg + 1'b1;
    end
  end
endmodule

// File: rtl/score_keeper.sv
// N-digit BCD game score with tick prescaler, saturation, high-score commit
// at game over and a milestone pulse.
module score_keeper
  import score_pkg::*;
#(
  parameter int NUM_DIGITS      = 5,
  parameter int TICK_DIV        = 6,
  parameter int MILESTONE_DIGIT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      game_start,
  input  logic                      game_frozen,
  input  logic                      game_tick,
  input  logic                      clear_hi,
  output logic [4*NUM_DIGITS-1:0]   score,
  output logic [4*NUM_DIGITS-1:0]   hi_score,
  output logic                      new_hi,
  output logic                      milestone_pulse,
  output logic                      overflow
);
  localparam int W = DIGIT_W * NUM_DIGITS;

  state_t         state_reg, state_next;
  logic [7:0]     presc_reg;
  logic [W-1:0]   score_vec;
  logic [W-1:0]   hi_reg;
  logic           new_hi_reg, ms_reg, ovf_reg;
  logic [NUM_DIGITS:0] carry;
  logic           tick_run, presc_wrap, inc_req, inc_en, saturated, beats_hi;

  // Digit 0 always sees a carry, so the chain doubles as the all-nines detector.
  assign carry[0]   = 1'b1;
  assign saturated  = carry[NUM_DIGITS];

  assign tick_run   = (state_reg == RUN) & ~game_frozen & game_tick & ~game_start;
  assign presc_wrap = (presc_reg == 8'(TICK_DIV - 1));
  assign inc_req    = tick_run & presc_wrap;
  assign inc_en     = inc_req & ~saturated;
  assign beats_hi   = (score_vec > hi_reg);

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      score_bcd_digit u_digit (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (game_start),
        .inc_en    (inc_en),
        .carry_in  (carry[gi]),
        .digit     (score_vec[gi*DIGIT_W +: DIGIT_W]),
        .carry_out (carry[gi+1])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = IDLE;
      RUN:     if (game_frozen) state_next = COMMIT;
      COMMIT:  state_next = OVER;
      default: state_next = OVER;
    endcase
    if (game_start) state_next = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      presc_reg  <= '0;
      hi_reg     <= '0;
      new_hi_reg <= 1'b0;
      ms_reg     <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      ms_reg    <= inc_en & carry[MILESTONE_DIGIT];

      if (game_start)    presc_reg <= '0;
      else if (tick_run) presc_reg <= presc_wrap ? 8'd0 : presc_reg + 8'd1;

      if (game_start)                     ovf_reg <= 1'b0;
      else if (inc_req && saturated)      ovf_reg <= 1'b1;

      // clear_hi wins over a commit; the commit itself still uses the pre-clear score.
      if (clear_hi)                               hi_reg <= '0;
      else if (state_reg == COMMIT && beats_hi)   hi_reg <= score_vec;

      if (clear_hi || game_start)  new_hi_reg <= 1'b0;
      else if (state_reg == COMMIT) new_hi_reg <= beats_hi;
    end
  end

  assign score           = score_vec;
  assign hi_score        = hi_reg;
  assign new_hi          = new_hi_reg;
  assign milestone_pulse = ms_reg;
  assign overflow        = ovf_reg;
endmodule
